// File: rtl/display_scan_ctrl.sv
// Seven-segment scan controller: blanked one-hot anode scan, hex decode, frame-synchronous double buffer.
// Outputs lag the scan state by one cycle; no backpressure, and host writes are always accepted.
module display_scan_ctrl #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] digit_mask,
    output logic [7:0] anode,
    output logic [6:0] seg,
    output logic       dp,
    output logic       refresh_en,
    output logic [2:0] scan_idx,
    output logic       frame_done
);

    localparam int PC_W = $clog2(PRESCALE);
    localparam logic [PC_W-1:0] PC_LAST       = PC_W'(PRESCALE - 1);
    localparam logic [PC_W-1:0] PC_BLANK_LAST = PC_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [2:0]      IDX_LAST      = 3'(DIGITS - 1);

    typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

    // With no blanking the slot opens directly in SHOW.
    localparam state_t SLOT_START = (BLANK_CYCLES > 0) ? BLANK : SHOW;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            pending;
    logic [4:0]      shadow [8];
    logic [4:0]      active [8];

    logic       wr_ok;
    logic       slot_end;
    logic       frame_end;
    logic       show_on;
    logic [4:0] cur;

    function automatic logic [6:0] hex2seg(input logic [3:0] h);
        case (h)
            4'h0: hex2seg = 7'b1000000;
            4'h1: hex2seg = 7'b1111001;
            4'h2: hex2seg = 7'b0100100;
            4'h3: hex2seg = 7'b0110000;
            4'h4: hex2seg = 7'b0011001;
            4'h5: hex2seg = 7'b0010010;
            4'h6: hex2seg = 7'b0000010;
            4'h7: hex2seg = 7'b1111000;
            4'h8: hex2seg = 7'b0000000;
            4'h9: hex2seg = 7'b0010000;
            4'hA: hex2seg = 7'b0001000;
            4'hB: hex2seg = 7'b0000011;
            4'hC: hex2seg = 7'b1000110;
            4'hD: hex2seg = 7'b0100001;
            4'hE: hex2seg = 7'b0000110;
            default: hex2seg = 7'b0001110;
        endcase
    endfunction

    assign wr_ok     = wr_en && (int'(wr_addr) < DIGITS);
    assign slot_end  = en && (state == SHOW) && (pc == PC_LAST);
    assign frame_end = slot_end && (scan_idx == IDX_LAST);
    assign cur       = active[scan_idx];
    assign show_on   = (state == SHOW) && digit_mask[scan_idx];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            pc         <= '0;
            scan_idx   <= '0;
            pending    <= 1'b0;
            anode      <= 8'hFF;
            seg        <= 7'h7F;
            dp         <= 1'b1;
            refresh_en <= 1'b0;
            frame_done <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            refresh_en <= 1'b0;
            frame_done <= 1'b0;

            if (show_on) begin
                anode <= ~(8'b1 << scan_idx);
                seg   <= hex2seg(cur[3:0]);
                dp    <= ~cur[4];
            end else begin
                anode <= 8'hFF;
                seg   <= 7'h7F;
                dp    <= 1'b1;
            end

            // Commit copies pre-edge shadow; a coincident write stays pending for the next frame.
            if (frame_end && pending) begin
                for (int i = 0; i < 8; i++) begin
                    active[i] <= shadow[i];
                end
            end
            if (wr_ok) begin
                shadow[wr_addr] <= wr_data;
                pending         <= 1'b1;
            end else if (frame_end) begin
                pending <= 1'b0;
            end

            if (!en) begin
                state    <= IDLE;
                pc       <= '0;
                scan_idx <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= SLOT_START;
                        pc    <= '0;
                    end
                    BLANK: begin
                        pc <= pc + PC_W'(1);
                        if (pc == PC_BLANK_LAST) begin
                            state <= SHOW;
                        end
                    end
                    default: begin
                        if (pc == PC_LAST) begin
                            pc         <= '0;
                            state      <= SLOT_START;
                            refresh_en <= 1'b1;
                            scan_idx   <= (scan_idx == IDX_LAST) ? 3'd0 : scan_idx + 3'd1;
                            frame_done <= (scan_idx == IDX_LAST);
                        end else begin
                            pc <= pc + PC_W'(1);
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Bench for display_scan_ctrl: two configurations driven in parallel against a time-based scan model.
module tb_display_scan_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] digit_mask;

    logic [7:0] anode_o [2];
    logic [6:0] seg_o   [2];
    logic       dp_o    [2];
    logic       tick_o  [2];
    logic       fd_o    [2];
    logic [2:0] idx_o   [2];

    display_scan_ctrl #(.DIGITS(8), .PRESCALE(8), .BLANK_CYCLES(2)) dut0 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_mask(digit_mask), .anode(anode_o[0]), .seg(seg_o[0]), .dp(dp_o[0]),
        .refresh_en(tick_o[0]), .scan_idx(idx_o[0]), .frame_done(fd_o[0])
    );

    display_scan_ctrl #(.DIGITS(1), .PRESCALE(8), .BLANK_CYCLES(0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .digit_mask(digit_mask), .anode(anode_o[1]), .seg(seg_o[1]), .dp(dp_o[1]),
        .refresh_en(tick_o[1]), .scan_idx(idx_o[1]), .frame_done(fd_o[1])
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model parameters per instance.
    int m_d [2] = '{8, 1};
    int m_p [2] = '{8, 8};
    int m_b [2] = '{2, 0};

    // Lit segments (active-high, bit 0 = a) for hex glyphs 0..F.
    logic [6:0] lit [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: t counts enabled cycles since the scan (re)started.
    bit         run  [2];
    int         t    [2];
    bit         pend [2];
    logic [4:0] sh   [2][8];
    logic [4:0] ac   [2][8];

    logic [7:0] e_anode [2];
    logic [6:0] e_seg   [2];
    logic       e_dp    [2];
    logic       e_tick  [2];
    logic       e_fd    [2];
    logic [2:0] e_idx   [2];

    function automatic int slot_of(input int k);
        return run[k] ? (t[k] / m_p[k]) % m_d[k] : 0;
    endfunction

    function automatic int pc_of(input int k);
        return run[k] ? t[k] % m_p[k] : 0;
    endfunction

    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            int s, p;
            bit show, commit;
            if (!rst) begin
                run[k] = 0; t[k] = 0; pend[k] = 0;
                for (int i = 0; i < 8; i++) begin sh[k][i] = '0; ac[k][i] = '0; end
                e_anode[k] = 8'hFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
                e_tick[k] = 1'b0; e_fd[k] = 1'b0; e_idx[k] = 3'd0;
            end else begin
                s = slot_of(k);
                p = pc_of(k);
                show = run[k] && (p >= m_b[k]) && digit_mask[s];
                if (show) begin
                    e_anode[k] = ~(8'd1 << s);
                    e_seg[k]   = ~lit[ac[k][s][3:0]];
                    e_dp[k]    = ~ac[k][s][4];
                end else begin
                    e_anode[k] = 8'hFF; e_seg[k] = 7'h7F; e_dp[k] = 1'b1;
                end
                e_tick[k] = 1'b0; e_fd[k] = 1'b0; commit = 0;
                if (!en) begin
                    run[k] = 0; t[k] = 0;
                end else if (!run[k]) begin
                    run[k] = 1; t[k] = 0;
                end else begin
                    t[k]++;
                    if (t[k] % m_p[k] == 0) begin
                        e_tick[k] = 1'b1;
                        if ((t[k] / m_p[k]) % m_d[k] == 0) begin
                            e_fd[k] = 1'b1;
                            commit = pend[k];
                        end
                    end
                end
                if (commit) begin
                    for (int i = 0; i < 8; i++) ac[k][i] = sh[k][i];
                    pend[k] = 0;
                end
                if (wr_en && (int'(wr_addr) < m_d[k])) begin
                    sh[k][wr_addr] = wr_data;
                    pend[k] = 1;
                end
                e_idx[k] = 3'(slot_of(k));
            end
        end
    endtask

    task automatic chk(input string tag, input int k, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d cyc %0d: observed %h expected %h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge();
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("anode", k, anode_o[k], e_anode[k]);
            chk("seg", k, 8'(seg_o[k]), 8'(e_seg[k]));
            chk("dp", k, 8'(dp_o[k]), 8'(e_dp[k]));
            chk("refresh_en", k, 8'(tick_o[k]), 8'(e_tick[k]));
            chk("frame_done", k, 8'(fd_o[k]), 8'(e_fd[k]));
            chk("scan_idx", k, 8'(idx_o[k]), 8'(e_idx[k]));
        end
    endtask

    // Advance until instance 0 sits at slot s, count p (post-edge); expiry counts as a failure.
    task automatic run_to(input int s, input int p, input int limit);
        int n;
        bit hit;
        n = 0;
        hit = 0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = run[0] && slot_of(0) == s && pc_of(0) == p;
        end
        n_assert++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL run_to timeout cyc %0d: slot %0d pc %0d not reached", cyc, s, p);
        end
    endtask

    task automatic run_to_frame_edge(input int limit);
        int n;
        bit hit;
        n = 0;
        hit = run[0] && (t[0] + 1) % 8 == 0 && ((t[0] + 1) / 8) % 8 == 0;
        while (!hit && n < limit) begin
            step();
            n++;
            hit = run[0] && (t[0] + 1) % 8 == 0 && ((t[0] + 1) / 8) % 8 == 0;
        end
        n_assert++;
        assert (hit) else begin
            n_fail++;
            $error("FAIL frame_edge timeout cyc %0d", cyc);
        end
    endtask

    initial begin
        int ticks, frames;

        // Reset held with en and a write pending on the inputs.
        rst = 1'b0; en = 1'b1; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h1F; digit_mask = 8'hFF;
        repeat (3) step();
        chk("rst_anode", 0, anode_o[0], 8'hFF);
        chk("rst_seg", 0, 8'(seg_o[0]), 8'h7F);
        chk("rst_dp", 0, 8'(dp_o[0]), 8'h01);
        chk("rst_idx", 0, 8'(idx_o[0]), 8'h00);
        chk("rst_tick", 0, 8'(tick_o[0]), 8'h00);

        // Free-running scan over two frames.
        rst = 1'b1; wr_en = 1'b0;
        ticks = 0; frames = 0;
        repeat (129) begin
            step();
            ticks += int'(tick_o[0]);
            frames += int'(fd_o[0]);
        end
        chk("tick_count", 0, 8'(ticks), 8'd16);
        chk("frame_count", 0, 8'(frames), 8'd2);
        chk("d1_anode", 1, anode_o[1], 8'hFE);

        // Single-digit instance ignores an out-of-range address.
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 5'h08;
        step();
        wr_en = 1'b0;
        repeat (20) step();
        chk("d1_ignored_wr", 1, 8'(seg_o[1]), 8'h40);

        // Double buffer: mid-frame write held until frame end.
        run_to(1, 3, 200);
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 5'h1A;
        step();
        wr_en = 1'b0;
        run_to(3, 4, 200);
        chk("dbuf_old_seg", 0, 8'(seg_o[0]), 8'h40);
        run_to(0, 4, 200);
        run_to(3, 4, 200);
        chk("dbuf_new_seg", 0, 8'(seg_o[0]), 8'h08);
        chk("dbuf_new_dp", 0, 8'(dp_o[0]), 8'h00);

        // Write on the commit edge with an earlier write pending.
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 5'h07;
        step();
        wr_en = 1'b0;
        run_to_frame_edge(200);
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 5'h08;
        step();
        wr_en = 1'b0;
        chk("edge_fd", 0, 8'(fd_o[0]), 8'h01);
        run_to(0, 4, 200);
        chk("edge_old0", 0, 8'(seg_o[0]), 8'h40);
        run_to(5, 4, 200);
        chk("edge_d5", 0, 8'(seg_o[0]), 8'h78);
        run_to(0, 4, 200);
        chk("edge_new0", 0, 8'(seg_o[0]), 8'h00);

        // Mask off upper digits, then abandon a slot mid-way.
        digit_mask = 8'h0F;
        run_to(5, 4, 200);
        chk("mask_off", 0, anode_o[0], 8'hFF);
        run_to(2, 4, 200);
        chk("mask_on", 0, anode_o[0], 8'hFB);
        digit_mask = 8'hFF;
        run_to(6, 5, 200);
        en = 1'b0;
        step();
        step();
        chk("dis_anode", 0, anode_o[0], 8'hFF);
        chk("dis_idx", 0, 8'(idx_o[0]), 8'h00);
        chk("dis_tick", 0, 8'(tick_o[0]), 8'h00);
        en = 1'b1;
        step();
        step();
        chk("reen_idx", 0, 8'(idx_o[0]), 8'h00);
        chk("reen_blank", 0, anode_o[0], 8'hFF);

        // Randomized traffic including enable drops and occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst     = ($urandom_range(0, 299) != 0);
            en      = ($urandom_range(0, 99) != 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom);
            wr_data = 5'($urandom);
            if ($urandom_range(0, 49) == 0) digit_mask = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
# display_scan_ctrl

Multiplexed seven-segment display scan controller. It generates the per-digit refresh tick that steps the 3-bit refresh counter, drives one-hot active-low anodes with a blanking guard at each digit change, decodes hex digit values to segments, and double-buffers digit contents so that host updates take effect only at frame boundaries. It sits between the host/datapath result registers and the board display pins.

## Interface

Parameters:
- DIGITS, 8, number of scanned digits, legal range 1..8.
- PRESCALE, 50000, clock cycles per digit slot, at least 2.
- BLANK_CYCLES, 4, cycles at the start of each slot with all anodes off, 0 ≤ BLANK_CYCLES < PRESCALE.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- en  in  1  scan enable.
- wr_en  in  1  write strobe to the shadow digit registers.
- wr_addr  in  3  digit index to write.
- wr_data  in  5  {dp, hex[3:0]} value for the digit.
- digit_mask  in  8  per-digit enable; bit i = 0 keeps anode i off during its slot.
- anode  out  8  active-low one-hot anode drive; bits at index ≥ DIGITS are always 1.
- seg  out  7  active-low segments {g,f,e,d,c,b,a}.
- dp  out  1  active-low decimal point.
- refresh_en  out  1  one-cycle tick that advances the external refresh counter.
- scan_idx  out  3  index of the current slot.
- frame_done  out  1  one-cycle pulse when the last slot completes.

## Operation

- Storage: 8 shadow and 8 active 5-bit registers, plus a pending flag.
- Writes: when wr_en = 1 and wr_addr < DIGITS, wr_data is written to shadow[wr_addr] and pending is set. Writes with wr_addr ≥ DIGITS are ignored.
- Commit: at the end of a frame, if pending = 1, all shadow registers are copied to active and pending is cleared.
- Write on the commit edge: the commit copies the shadow contents from before that edge. The new write lands in shadow and pending stays set, so it commits at the next frame.
- FSM states:
  - IDLE: en = 0. The prescaler count pc = 0 and scan_idx = 0.
  - BLANK: pc < BLANK_CYCLES.
  - SHOW: BLANK_CYCLES ≤ pc ≤ PRESCALE-1.
- Transitions:
  - IDLE → BLANK when en = 1.
  - BLANK → SHOW when pc reaches BLANK_CYCLES.
  - SHOW → BLANK at pc = PRESCALE-1 (end of slot).
  - Any state → IDLE when en = 0. This takes effect on the next edge, with pc and scan_idx cleared. A partial slot is abandoned and gives no refresh_en.
- BLANK_CYCLES = 0: the BLANK state is never entered.
- End of slot (edge where pc = PRESCALE-1): pc ← 0, scan_idx ← (scan_idx+1) mod DIGITS, refresh_en ← 1 for one cycle.
- End of frame: if scan_idx was DIGITS-1 on that edge, frame_done ← 1 for one cycle and the commit rule applies.
- Decode: the hex value 0-F maps to the standard seven-segment glyphs, active-low.
  - Examples: 0 → 7'b1000000, 8 → 7'b0000000, F → 7'b0001110.
- Output drive:
  - In SHOW with digit_mask[scan_idx] = 1: anode = ~(1 << scan_idx), seg = decode(active[scan_idx].hex), dp = ~active[scan_idx].dp.
  - In all other cases: anode = 8'hFF, seg = 7'h7F, dp = 1.

## Timing

- Reset (rst = 0 at an edge): state = IDLE, pc = 0, scan_idx = 0, pending = 0, all shadow and active registers = 0.
  - Output reset values: anode = 8'hFF, seg = 7'h7F, dp = 1, refresh_en = 0, frame_done = 0.
- Reset dominates en and wr_en on the same edge. A mid-slot reset aborts the slot, with no tick and no commit.
- anode, seg and dp are registered. They reflect the state, scan_idx and active registers of the previous cycle, i.e. a one-cycle lag.
- refresh_en and frame_done are registered and high in the first cycle of the new slot, coincident with the updated scan_idx.
- Slot period = PRESCALE cycles; frame period = DIGITS × PRESCALE cycles.
- Anode-on time per slot = PRESCALE - BLANK_CYCLES cycles. There is never an edge where two anode bits are low.
- DIGITS = 1: scan_idx stays 0, and refresh_en and frame_done pulse together every PRESCALE cycles.
- Committed data first appears in the SHOW phase of slot 0 of the following frame.
- Write-to-display latency is at most 2 frames + 1 cycle.

## Test plan

All tests use PRESCALE = 8, BLANK_CYCLES = 2, DIGITS = 8 unless noted.

1. Reset: hold rst = 0 for 3 cycles with en = 1 and wr_en = 1 → anode = FF, seg = 7F, dp = 1, scan_idx = 0, refresh_en = 0; no later commit is observed.
2. Scan: en = 1, digit_mask = FF, active registers all 0 → refresh_en pulses every 8 cycles; scan_idx steps 0..7 then wraps to 0; frame_done pulses on the 7→0 step; anode low for 6 of 8 cycles per slot, values FE, FD, …, 7F.
3. Double buffer: write addr 3 = 5'h1A mid-frame → digit 3 keeps seg = 7'h40 until frame_done; in the next frame's slot 3, seg = 7'h08 and dp = 0.
4. Write on commit edge: write addr 0 = 5'h08 on the edge where frame_done asserts, with an earlier pending write → the earlier write is committed, addr 0 shows the old value for one more frame, then shows 7'h00.
5. Mask and disable: digit_mask = 8'h0F → anode stays FF during slots 4..7 while ticks continue. Deassert en at pc = 5 → within one cycle anode = FF, no tick, scan_idx = 0; on re-enable the scan restarts at slot 0 in BLANK.
6. DIGITS = 1, BLANK_CYCLES = 0 → anode = FE continuously; refresh_en and frame_done pulse together every 8 cycles; a write with wr_addr = 2 is ignored.
